// File: rtl/eth_rx_gate_pkg.sv
// Shared definitions for the Ethernet receive frame gate: stored word layout,
// write-side FSM encoding and a saturating counter helper.
package eth_rx_gate_pkg;

    localparam int ERR_BIT = 3;
    localparam int BYTES_W = 3;
    localparam int DATA_W  = 64;
    localparam int WORD_W  = 68;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DROP   = 2'd2
    } wr_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/eth_rx_gate_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// shaped for block-RAM inference.
module eth_rx_gate_ram
    import eth_rx_gate_pkg::*;
#(
    parameter int SIZE  = 11,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [SIZE-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_gate.sv
// Store-and-forward gate on the MAC receive stream: frames are buffered whole
// and only complete, error-free frames that fit are released downstream.
//
// state     | meaning
// ST_IDLE   | between frames; the next beat opens a new frame
// ST_ACCEPT | mid-frame; beats written speculatively beyond commit_ptr
// ST_DROP   | discarding the rest of an overflowed or flushed frame
module eth_rx_frame_gate
    import eth_rx_gate_pkg::*;
#(
    parameter int SIZE    = 11,
    parameter bit USE_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [63:0] s_tdata,
    input  logic [3:0]  s_tuser,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [63:0] m_tdata,
    output logic [3:0]  m_tuser,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] stat_pkt_ok,
    output logic [31:0] stat_drop_err,
    output logic [31:0] stat_drop_ovf
);

    localparam logic [SIZE-1:0] PTR_ONE = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE:0]   CNT_ONE = {{SIZE{1'b0}}, 1'b1};

    wr_state_t         state, state_cur, state_nx;
    logic [SIZE-1:0]   wr_ptr, wr_nx, commit_ptr, commit_nx, rd_ptr;
    logic [SIZE:0]     pkt_cnt;
    logic              first_cyc, quiet, quiet_cur, quiet_nx, resync_drop;
    logic              beat, full, frame_err, wr_en, commit_ev, in_flight;
    logic              inc_ok, inc_err, inc_ovf;
    logic              avail, out_take, rd_en, rq_valid, last_xfer;
    logic [WORD_W-1:0] wr_word, rd_word;

    assign s_tready  = ~reset;
    assign beat      = s_tvalid & s_tready;
    assign frame_err = USE_ERR & s_tuser[ERR_BIT];
    assign full      = (wr_ptr + PTR_ONE) == rd_ptr;
    assign wr_word   = {s_tlast, s_tuser[BYTES_W-1:0], s_tdata};

    // A non-last beat on the first cycle after reset is the tail of a frame
    // whose head was lost; swallow it silently.
    assign resync_drop = first_cyc & beat & ~s_tlast;
    assign state_cur   = resync_drop ? ST_DROP : state;
    assign quiet_cur   = quiet | resync_drop;
    assign in_flight   = (state_cur != ST_IDLE || beat) && !(beat && s_tlast);

    always_comb begin
        state_nx  = state_cur;
        wr_nx     = wr_ptr;
        commit_nx = commit_ptr;
        quiet_nx  = quiet_cur;
        wr_en     = 1'b0;
        commit_ev = 1'b0;
        inc_ok    = 1'b0;
        inc_err   = 1'b0;
        inc_ovf   = 1'b0;
        case (state_cur)
            ST_IDLE, ST_ACCEPT: begin
                if (beat) begin
                    if (!full) begin
                        wr_en = 1'b1;
                        wr_nx = wr_ptr + PTR_ONE;
                        if (s_tlast) begin
                            state_nx = ST_IDLE;
                            if (frame_err) begin
                                wr_nx   = commit_ptr;
                                inc_err = 1'b1;
                            end else begin
                                commit_nx = wr_ptr + PTR_ONE;
                                commit_ev = 1'b1;
                                inc_ok    = 1'b1;
                            end
                        end else begin
                            state_nx = ST_ACCEPT;
                        end
                    end else begin
                        wr_nx = commit_ptr;
                        if (s_tlast) begin
                            inc_ovf  = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            quiet_nx = 1'b0;
                            state_nx = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_tlast) begin
                    inc_ovf  = ~quiet_cur;
                    quiet_nx = 1'b0;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            quiet      <= 1'b0;
            first_cyc  <= 1'b1;
        end else begin
            first_cyc <= 1'b0;
            if (clear) begin
                wr_ptr     <= '0;
                commit_ptr <= '0;
                state      <= in_flight ? ST_DROP : ST_IDLE;
                quiet      <= in_flight;
            end else begin
                wr_ptr     <= wr_nx;
                commit_ptr <= commit_nx;
                state      <= state_nx;
                quiet      <= quiet_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pkt_ok   <= '0;
            stat_drop_err <= '0;
            stat_drop_ovf <= '0;
        end else if (clear) begin
            stat_pkt_ok   <= '0;
            stat_drop_err <= '0;
            stat_drop_ovf <= '0;
        end else begin
            stat_pkt_ok   <= sat_inc(stat_pkt_ok, inc_ok);
            stat_drop_err <= sat_inc(stat_drop_err, inc_err);
            stat_drop_ovf <= sat_inc(stat_drop_ovf, inc_ovf);
        end
    end

    // Two-stage read pipeline (RAM output register, then m_* register); the
    // RAM read is only issued when its result has somewhere to go.
    assign avail     = (pkt_cnt != '0) && (rd_ptr != commit_ptr);
    assign out_take  = ~m_tvalid | m_tready;
    assign rd_en     = avail & (~rq_valid | out_take) & ~clear;
    assign last_xfer = m_tvalid & m_tready & m_tlast;

    eth_rx_gate_ram #(
        .SIZE  (SIZE),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en & ~clear),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .re      (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            rq_valid <= 1'b0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= '0;
        end else if (clear) begin
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            rq_valid <= 1'b0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rq_valid <= rd_en | (rq_valid & ~out_take);
            if (out_take) begin
                m_tvalid <= rq_valid;
                if (rq_valid) begin
                    m_tdata <= rd_word[DATA_W-1:0];
                    m_tuser <= {1'b0, rd_word[DATA_W +: BYTES_W]};
                    m_tlast <= rd_word[WORD_W-1];
                end
            end
            case ({commit_ev, last_xfer})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_gate.sv
// Bench for eth_rx_frame_gate: driver pushes expected beats of good frames to a
// scoreboard queue, an independent monitor pops and compares released beats.
module tb_eth_rx_frame_gate;

    localparam int CAP = 15;

    typedef struct packed {
        logic        last;
        logic [2:0]  bytes;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [63:0] s_tdata;
    logic [3:0]  s_tuser;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [3:0]  m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] stat_pkt_ok;
    logic [31:0] stat_drop_err;
    logic [31:0] stat_drop_ovf;

    beat_t sb[$];
    beat_t mon_exp;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_ok  = 0;
    int    exp_err = 0;
    int    exp_ovf = 0;
    int    rdy_mode = 1;

    always #5 clk = ~clk;

    eth_rx_frame_gate #(
        .SIZE    (4),
        .USE_ERR (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .s_tdata       (s_tdata),
        .s_tuser       (s_tuser),
        .s_tlast       (s_tlast),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tuser       (m_tuser),
        .m_tlast       (m_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .stat_pkt_ok   (stat_pkt_ok),
        .stat_drop_err (stat_drop_err),
        .stat_drop_ovf (stat_drop_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got beat data %0h, expected no output", m_tdata);
            end else begin
                mon_exp = sb.pop_front();
                check("out_data", m_tdata, mon_exp.data);
                check("out_user", 64'(m_tuser), 64'({1'b0, mon_exp.bytes}));
                check("out_last", 64'(m_tlast), 64'(mon_exp.last));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // last_bytes < 0 picks random byte counts; clear_beat >= 0 pulses clear with that beat
    task automatic send_frame(input int len, input bit err, input bit push,
                              input int last_bytes, input int clear_beat);
        beat_t b;
        beat_t fr[$];
        for (int i = 0; i < len; i++) begin
            b.data  = {$urandom, $urandom};
            b.last  = (i == len - 1);
            b.bytes = (b.last && last_bytes >= 0) ? 3'(last_bytes) : 3'($urandom_range(0, 7));
            s_tvalid = 1'b1;
            s_tdata  = b.data;
            s_tlast  = b.last;
            s_tuser  = {b.last ? err : 1'($urandom_range(0, 1)), b.bytes};
            clear    = (i == clear_beat);
            fr.push_back(b);
            if (b.last && push) begin
                foreach (fr[k]) sb.push_back(fr[k]);
            end
            @(posedge clk);
            #1;
            clear = 1'b0;
            if (i == clear_beat) begin
                check("clear_tvalid", 64'(m_tvalid), 64'(0));
                sb.delete();
                exp_ok  = 0;
                exp_err = 0;
                exp_ovf = 0;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 2000) begin
            tick(1);
            cyc++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats still pending after %0d cycles, expected 0", name, sb.size(), cyc);
        end
        tick(4);
        check({name, "_idle"}, 64'(m_tvalid), 64'(0));
    endtask

    task automatic check_stats(input string name);
        check({name, "_ok"},  64'(stat_pkt_ok),   64'(exp_ok));
        check({name, "_err"}, 64'(stat_drop_err), 64'(exp_err));
        check({name, "_ovf"}, 64'(stat_drop_ovf), 64'(exp_ovf));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        tick(3);
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tlast",  64'(m_tlast),  64'(0));
        check("rst_tdata",  m_tdata,       64'(0));
        check("rst_tuser",  64'(m_tuser),  64'(0));
        check("rst_tready", 64'(s_tready), 64'(0));
        check_stats("rst");
        reset = 1'b0;
        tick(2);
        check("run_tready", 64'(s_tready), 64'(1));

        // good 8-beat frame, latency of two cycles after commit
        rdy_mode = 1;
        tick(2);
        send_frame(8, 1'b0, 1'b1, 4, -1);
        exp_ok++;
        check("lat_c0", 64'(m_tvalid), 64'(0));
        tick(1);
        check("lat_c1", 64'(m_tvalid), 64'(0));
        tick(1);
        check("lat_c2", 64'(m_tvalid), 64'(1));
        drain("good8");
        check_stats("good8");

        // errored frame followed by a good one
        send_frame(5, 1'b1, 1'b0, -1, -1);
        exp_err++;
        send_frame(3, 1'b0, 1'b1, -1, -1);
        exp_ok++;
        drain("err");
        check_stats("err");

        // overflow with output stalled, then a frame that fits
        rdy_mode = 0;
        tick(2);
        send_frame(20, 1'b0, 1'b0, -1, -1);
        exp_ovf++;
        tick(4);
        check("ovf_no_out", 64'(m_tvalid), 64'(0));
        send_frame(10, 1'b0, 1'b1, -1, -1);
        exp_ok++;
        tick(6);
        check("stall_valid", 64'(m_tvalid), 64'(1));
        check("stall_data", m_tdata, sb[0].data);
        tick(3);
        check("stall_hold", m_tdata, sb[0].data);
        rdy_mode = 1;
        drain("ovf");
        check_stats("ovf");

        // back-to-back single-beat frames, random ready
        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            send_frame(1, 1'b0, 1'b1, -1, -1);
            exp_ok++;
        end
        drain("b2b");
        check("b2b_pktcnt", 64'(dut.pkt_cnt), 64'(0));
        check_stats("b2b");

        // random frames sized so the buffer never overflows
        for (int f = 0; f < 40; f++) begin
            int len;
            bit err;
            int waitc;
            len   = $urandom_range(1, 8);
            err   = ($urandom_range(0, 3) == 0);
            waitc = 0;
            while (sb.size() + len > CAP && waitc < 500) begin
                tick(1);
                waitc++;
            end
            if (waitc >= 500) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_space: %0d beats pending after %0d cycles, expected room", sb.size(), waitc);
            end
            send_frame(len, err, !err, -1, -1);
            if (err) exp_err++;
            else exp_ok++;
            tick($urandom_range(0, 2));
        end
        drain("rand");
        check_stats("rand");

        // clear mid-frame while two frames are stored
        rdy_mode = 0;
        tick(2);
        send_frame(3, 1'b0, 1'b1, -1, -1);
        send_frame(2, 1'b0, 1'b1, -1, -1);
        tick(4);
        check("pre_clear_valid", 64'(m_tvalid), 64'(1));
        send_frame(6, 1'b0, 1'b0, -1, 2);
        tick(2);
        check("clear_drop", 64'(m_tvalid), 64'(0));
        check_stats("clear0");
        rdy_mode = 1;
        send_frame(4, 1'b0, 1'b1, -1, -1);
        exp_ok++;
        drain("clear");
        check_stats("clear");

        // async reset during an output burst
        send_frame(8, 1'b0, 1'b1, -1, -1);
        exp_ok++;
        tick(4);
        check("pre_rst_valid", 64'(m_tvalid), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", 64'(m_tvalid), 64'(0));
        sb.delete();
        exp_ok  = 0;
        exp_err = 0;
        exp_ovf = 0;
        tick(2);
        reset = 1'b0;
        tick(2);
        check_stats("rst0");
        send_frame(5, 1'b0, 1'b1, -1, -1);
        exp_ok++;
        drain("rst");
        check_stats("rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
